spi_slave: RTL



---
 rtl/spi_slave.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//
// SPI target that runs entirely in the system clock domain. The ss, sck and
// mosi pins pass through SYNC_STAGES-deep synchronizers. All shifting happens
// on sck edges detected in the synchronized sck. It supports all four
// cpol/cpha modes and transfers of 1..16 bits, MSB first.
//
// Optional feature: define SPI_SLAVE_OVERRUN_EN to build the sticky overrun
// flag on ovr. When the macro is undefined, ovr is tied low.
//
// Handshake: we loads din into the tx shifter, but only while idle. done
// pulses for one clk when a transfer completes; at the same time dout is
// updated and rx_valid is set. oe acknowledges dout and clears rx_valid. If a
// completion and oe land in the same clk, rx_valid stays set.
//
// Parameters
//   WIDTH        shift register / data port width (>= 16, xfer_len reaches 15)
//   SYNC_STAGES  synchronizer depth on ss, sck, mosi (>= 2)
//
// Ports
//   clk       system clock (sck period must be >= 8 clk periods)
//   rst       synchronous, active-high reset
//   ss        slave select, active low
//   sck       SPI clock from master
//   mosi      serial data from master
//   miso      serial data to master (0 while ss high or idle)
//   en        block enable; when low, ss is ignored and transfers abort
//   cpol      clock idle level
//   cpha      0: sample on leading edge, 1: sample on trailing edge
//   xfer_len  transfer length minus 1
//   we        load din into the tx shifter (idle only)
//   din       tx word, right-justified
//   oe        read acknowledge, clears rx_valid (and ovr)
//   dout      last received word, right-justified, upper bits zero
//   rx_valid  dout holds unread data
//   busy      state != IDLE
//   done      one-clk pulse on transfer completion
//   ovr       sticky overrun flag
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic             en,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [3:0]       xfer_len,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             oe,
  output logic [WIDTH-1:0] dout,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ovr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_SS = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  // Synchronizers. The ss chain resets high so that an idle bus does not
  // look like a select right after reset.
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   ss_q;
  logic                   sck_q;

  // Mode and length are captured at ss assertion. Input changes during a
  // transfer are therefore ignored until the next select.
  logic                   cpol_l;
  logic                   cpha_l;
  logic [3:0]             len_l;

  logic [WIDTH-1:0]       tx;
  logic [WIDTH-1:0]       tx_load;
  logic [WIDTH-2:0]       rx_shift;
  logic [WIDTH-1:0]       rx_next;
  logic [WIDTH-1:0]       len_mask;
  logic [4:0]             bit_cnt;
  logic                   miso_q;

  logic                   ss_fall;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic                   shift_edge;

  // FSM decode outputs
  logic                   start;
  logic                   abort;
  logic                   sample_go;
  logic                   shift_go;
  logic                   finish;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall  = ss_q & ~ss_s;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  assign lead_edge   = cpol_l ? sck_fall : sck_rise;
  assign trail_edge  = cpol_l ? sck_rise : sck_fall;
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge  : trail_edge;

  // If we and the select arrive in the same clk, the new din is transmitted.
  assign tx_load = we ? din : tx;
  assign rx_next = {rx_shift, mosi_s};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      len_mask[i] = (i <= int'(len_l));
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    abort     = 1'b0;
    sample_go = 1'b0;
    shift_go  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (en && ss_fall) begin
          start   = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        // In ACTIVE, ss_s can only be high because it has just risen.
        if (ss_s || !en) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          if (sample_edge) begin
            sample_go = 1'b1;
            if (bit_cnt == {1'b0, len_l}) begin
              finish  = 1'b1;
              state_n = WAIT_SS;
            end
          end
          if (shift_edge) begin
            shift_go = 1'b1;
          end
        end
      end
      WAIT_SS: begin
        if (ss_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_q      <= 1'b1;
      sck_q     <= 1'b0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      len_l     <= '0;
      tx        <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
      dout      <= '0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_q      <= ss_s;
      sck_q     <= sck_s;
      done      <= finish;

      if (start) begin
        cpol_l   <= cpol;
        cpha_l   <= cpha;
        len_l    <= xfer_len;
        bit_cnt  <= '0;
        rx_shift <= '0;
        if (cpha) begin
          // The first leading edge drives the first bit.
          tx     <= tx_load;
          miso_q <= 1'b0;
        end else begin
          // The first bit must be on the wire before the first leading edge.
          tx     <= {tx_load[WIDTH-2:0], 1'b0};
          miso_q <= tx_load[xfer_len];
        end
      end else if (abort) begin
        // The partial word is dropped. The next transfer needs a fresh we.
        tx      <= '0;
        bit_cnt <= '0;
      end else begin
        if (state == IDLE && we) begin
          tx <= din;
        end
        // The next outgoing bit always sits at position len_l.
        if (shift_go) begin
          miso_q <= tx[len_l];
          tx     <= {tx[WIDTH-2:0], 1'b0};
        end
        if (sample_go) begin
          rx_shift <= rx_next[WIDTH-2:0];
          bit_cnt  <= bit_cnt + 5'd1;
        end
        if (finish) begin
          dout <= rx_next & len_mask;
        end
      end

      // A completion overrides an acknowledge in the same clk.
      if (finish) begin
        rx_valid <= 1'b1;
      end else if (oe) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (finish && rx_valid && !oe) begin
      ovr_q <= 1'b1;
    end else if (oe) begin
      ovr_q <= 1'b0;
    end
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign miso = miso_q & ~ss_s & (state != IDLE);

endmodule
